// File: rtl/fp_operand_serializer_pkg.sv
// rtl/fp_operand_serializer_pkg.sv - shared constants, state encoding and byte-select helper for the operand serializer
package fp_operand_serializer_pkg;

  localparam int FP_WIDTH     = 64;
  localparam int SEND_BYTES   = 16;
  localparam int RESULT_BYTES = 8;
  localparam int BYTE_CNT_W   = 4;
  localparam int RES_CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RES,
    ST_GUARD
  } ser_state_e;

  // Operand A occupies the low half so bytes 0-7 are A and 8-15 are B.
  typedef struct packed {
    logic [FP_WIDTH-1:0] b;
    logic [FP_WIDTH-1:0] a;
  } fp_pair_t;

  function automatic logic [7:0] pair_byte(input fp_pair_t p, input logic [BYTE_CNT_W-1:0] idx);
    logic [2*FP_WIDTH-1:0] flat;
    flat = p;
    return flat[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fp_pair_buffer.sv
// rtl/fp_pair_buffer.sv - two-entry active/pending operand pair holding buffer
module fp_pair_buffer
  import fp_operand_serializer_pkg::*;
(
  input  logic     CLK,
  input  logic     RESET,
  input  logic     push,
  input  fp_pair_t push_pair,
  input  logic     idle,
  input  logic     free_active,
  output logic     act_valid,
  output fp_pair_t act_pair,
  output logic     pend_valid
);

  fp_pair_t pend_pair;
  logic     load_act;
  logic     load_pend;
  logic     move_pend;

  // On release the older pending pair always wins the active slot; a pair
  // arriving on that same edge only takes active when nothing is pending.
  always_comb begin
    load_act  = 1'b0;
    load_pend = 1'b0;
    move_pend = 1'b0;
    if (free_active) begin
      if (pend_valid) begin
        move_pend = 1'b1;
        load_pend = push;
      end else begin
        load_act = push;
      end
    end else if (push) begin
      if (!act_valid && idle) begin
        load_act = 1'b1;
      end else begin
        load_pend = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      act_valid  <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      if (load_act || move_pend) begin
        act_valid <= 1'b1;
      end else if (free_active) begin
        act_valid <= 1'b0;
      end
      if (load_pend) begin
        pend_valid <= 1'b1;
      end else if (move_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load_act) begin
      act_pair <= push_pair;
    end else if (move_pend) begin
      act_pair <= pend_pair;
    end
    if (load_pend) begin
      pend_pair <= push_pair;
    end
  end

endmodule

// File: rtl/fp_operand_serializer.sv
// rtl/fp_operand_serializer.sv - streams binary64 operand pairs bytewise to a serial multiplier and waits for its result
module fp_operand_serializer
  import fp_operand_serializer_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                OP_VALID,
  output logic                OP_READY,
  input  logic [FP_WIDTH-1:0] OP_A,
  input  logic [FP_WIDTH-1:0] OP_B,
  output logic                ENABLE,
  output logic [7:0]          DATA_IN,
  input  logic                MULT_READY,
  output logic                BUSY,
  output logic                TIMEOUT_ERR
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);

  ser_state_e             state;
  ser_state_e             state_nxt;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [BYTE_CNT_W-1:0]  byte_cnt_nxt;
  logic [RES_CNT_W-1:0]   res_cnt;
  logic [RES_CNT_W-1:0]   res_cnt_nxt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [WAIT_W-1:0]      wait_cnt_nxt;
  logic [GUARD_W-1:0]     guard_cnt;
  logic [GUARD_W-1:0]     guard_cnt_nxt;
  logic                   timeout_nxt;
  logic                   accept;
  logic                   free_active;
  logic                   act_valid;
  logic                   pend_valid;
  fp_pair_t               act_pair;
  fp_pair_t               in_pair;

  // Ready is gated by RESET itself so it is low for the whole reset pulse.
  assign OP_READY = !pend_valid && !RESET;
  assign accept   = OP_VALID && OP_READY;
  assign in_pair  = '{b: OP_B, a: OP_A};

  fp_pair_buffer u_pair_buffer (
    .CLK         (CLK),
    .RESET       (RESET),
    .push        (accept),
    .push_pair   (in_pair),
    .idle        (state == ST_IDLE),
    .free_active (free_active),
    .act_valid   (act_valid),
    .act_pair    (act_pair),
    .pend_valid  (pend_valid)
  );

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    res_cnt_nxt   = res_cnt;
    wait_cnt_nxt  = wait_cnt;
    guard_cnt_nxt = guard_cnt;
    timeout_nxt   = 1'b0;
    free_active   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (act_valid) begin
          state_nxt    = ST_SEND;
          byte_cnt_nxt = '0;
        end
      end
      ST_SEND: begin
        byte_cnt_nxt = byte_cnt + 1'b1;
        if (byte_cnt == BYTE_CNT_W'(SEND_BYTES - 1)) begin
          state_nxt    = ST_WAIT_RES;
          res_cnt_nxt  = '0;
          wait_cnt_nxt = '0;
        end
      end
      ST_WAIT_RES: begin
        wait_cnt_nxt = wait_cnt + 1'b1;
        if (MULT_READY) begin
          res_cnt_nxt = res_cnt + 1'b1;
        end
        // A result completing on the last allowed cycle is not a timeout.
        if (MULT_READY && (res_cnt == RES_CNT_W'(RESULT_BYTES - 1))) begin
          state_nxt     = ST_GUARD;
          guard_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt   = 1'b1;
          state_nxt     = ST_GUARD;
          guard_cnt_nxt = '0;
        end
      end
      ST_GUARD: begin
        guard_cnt_nxt = guard_cnt + 1'b1;
        if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1)) begin
          free_active   = 1'b1;
          guard_cnt_nxt = '0;
          if (pend_valid || accept) begin
            state_nxt    = ST_SEND;
            byte_cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      res_cnt     <= '0;
      wait_cnt    <= '0;
      guard_cnt   <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      res_cnt     <= res_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      guard_cnt   <= guard_cnt_nxt;
      TIMEOUT_ERR <= timeout_nxt;
    end
  end

  assign ENABLE  = (state == ST_SEND);
  assign DATA_IN = ENABLE ? pair_byte(act_pair, byte_cnt) : 8'h00;
  assign BUSY    = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_operand_serializer.sv
// tb/tb_fp_operand_serializer.sv - randomized model-checked bench for the operand serializer
module tb_fp_operand_serializer;

  localparam int G  = 2;
  localparam int TO = 64;

  logic        CLK        = 1'b0;
  logic        RESET      = 1'b1;
  logic        OP_VALID   = 1'b0;
  logic [63:0] OP_A       = 64'h0;
  logic [63:0] OP_B       = 64'h0;
  logic        MULT_READY = 1'b0;
  logic        OP_READY;
  logic        ENABLE;
  logic [7:0]  DATA_IN;
  logic        BUSY;
  logic        TIMEOUT_ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transaction-level model: current pair with its absolute send window and
  // completion cycle, plus the queue of accepted pairs not yet started.
  logic [127:0] cur = '0;
  bit           cur_v = 1'b0;
  logic [127:0] q[$];
  int           st = 0;
  int           en_c = 0;
  int           d = 0;
  bit           tmo = 1'b0;
  bit           pat[64];
  int           mr_mode = 0;
  int           mr_lat = -1;
  bit           spur = 1'b0;

  fp_operand_serializer #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .OP_VALID    (OP_VALID),
    .OP_READY    (OP_READY),
    .OP_A        (OP_A),
    .OP_B        (OP_B),
    .ENABLE      (ENABLE),
    .DATA_IN     (DATA_IN),
    .MULT_READY  (MULT_READY),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result-strobe pattern for one transaction and where it must complete.
  task automatic start_pair(input int s);
    int lat;
    int ones;
    st = s;
    lat = (mr_lat >= 0) ? mr_lat : int'($urandom_range(0, 6));
    for (int i = 0; i < 64; i++) begin
      case (mr_mode)
        0: pat[i] = (i >= lat) && (i < lat + 8);
        1: pat[i] = (i < 4) || (i >= 7 && i < 11);
        2: pat[i] = 1'b0;
        default: pat[i] = 1'($urandom_range(0, 1));
      endcase
    end
    ones = 0;
    d = -1;
    for (int i = 0; i < TO; i++) begin
      if (pat[i]) begin
        ones++;
        if (ones == 8 && d < 0) d = i;
      end
    end
    tmo = (d < 0);
    if (d < 0) d = TO - 1;
    en_c = st + 16 + d + G;
  endtask

  always @(negedge CLK) begin
    logic       e_en;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_tmo;
    logic       e_rdy;
    logic       acc;
    int         widx;
    cyc++;
    if (RESET) begin
      chk("rst_enable", ENABLE, 0);
      chk("rst_data", DATA_IN, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_timeout", TIMEOUT_ERR, 0);
      chk("rst_ready", OP_READY, 0);
      cur_v = 1'b0;
      q.delete();
      MULT_READY = 1'b0;
    end else begin
      e_en   = cur_v && (cyc >= st) && (cyc < st + 16);
      e_data = e_en ? cur[8*(cyc-st) +: 8] : 8'h00;
      e_busy = cur_v && (cyc >= st) && (cyc <= en_c);
      e_tmo  = cur_v && tmo && (cyc == st + 16 + TO);
      e_rdy  = (q.size() == 0);
      chk("enable", ENABLE, e_en);
      chk("data_in", DATA_IN, e_data);
      chk("busy", BUSY, e_busy);
      chk("timeout_err", TIMEOUT_ERR, e_tmo);
      chk("op_ready", OP_READY, e_rdy);
      widx = cyc - (st + 16);
      if (cur_v && widx >= 0 && widx <= d) MULT_READY = pat[widx];
      else MULT_READY = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = OP_VALID && e_rdy;
      if (acc) begin
        if (!cur_v) begin
          cur   = {OP_B, OP_A};
          cur_v = 1'b1;
          start_pair(cyc + 2);
        end else begin
          q.push_back({OP_B, OP_A});
        end
      end
      if (cur_v && cyc == en_c) begin
        if (q.size() != 0) begin
          cur = q.pop_front();
          start_pair(cyc + 1);
        end else begin
          cur_v = 1'b0;
        end
      end
    end
  end

  task automatic send_pair(input logic [63:0] a, input logic [63:0] b);
    bit ok;
    ok = 1'b0;
    OP_A = a;
    OP_B = b;
    OP_VALID = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (OP_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge CLK);
      #1;
    end
    chk("accepted", ok, 1);
    OP_VALID = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (ENABLE) begin
        ok = 1'b1;
        break;
      end
    end
    chk("enable_seen", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!cur_v && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drained", ok, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    int          tmo_at;
    int          en_at;
    int          pulses;
    logic [7:0]  got[16];
    logic [7:0]  exp34[16];
    exp34 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h3F,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};

    repeat (3) @(negedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", OP_READY, 1);
    @(posedge CLK);
    #1;

    // Single known pair: literal byte stream and busy length (3 idle + 8 strobes + 2 guard).
    mr_mode = 0; mr_lat = 3; spur = 1'b0;
    send_pair(64'h3FF0000000000000, 64'h4000000000000000);
    wait_en(ok);
    got[0] = DATA_IN;
    for (int k = 1; k < 16; k++) begin
      @(negedge CLK);
      got[k] = DATA_IN;
    end
    for (int k = 0; k < 16; k++) chk("single_pair_byte", got[k], exp34[k]);
    n = 16;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!BUSY) break;
      n++;
    end
    chk("single_pair_busy_cycles", n, 29);
    wait_idle();

    // Gapped strobes 4-3-4 with spurious strobes outside the wait window.
    mr_mode = 1; spur = 1'b1;
    send_pair({$urandom, $urandom}, {$urandom, $urandom});
    wait_en(ok);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!BUSY) break;
      n++;
    end
    chk("gapped_busy_cycles", n, 29);
    spur = 1'b0;
    wait_idle();

    // Three pairs back-to-back.
    mr_mode = 0; mr_lat = -1;
    send_pair(64'h1111111111111111, 64'h2222222222222222);
    send_pair(64'h3333333333333333, 64'h4444444444444444);
    @(negedge CLK);
    chk("ready_low_two_buffered", OP_READY, 0);
    @(posedge CLK);
    #1;
    send_pair(64'h5555555555555555, 64'h6666666666666666);
    wait_idle();

    // Timeout on the first pair, then the pending pair streams.
    mr_mode = 2;
    send_pair(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    send_pair(64'hAAAA5555AAAA5555, 64'h5555AAAA5555AAAA);
    wait_en(ok);
    #1 mr_mode = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ENABLE) break;
      @(negedge CLK);
    end
    tmo_at = -1; en_at = -1; pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (TIMEOUT_ERR) begin
        pulses++;
        if (tmo_at < 0) tmo_at = i;
      end
      if (ENABLE && en_at < 0) en_at = i;
      @(negedge CLK);
    end
    chk("timeout_offset", tmo_at, 64);
    chk("timeout_pulses", pulses, 1);
    chk("pending_after_timeout", en_at, 66);
    wait_idle();

    // Pair offered exactly on the last guard cycle goes straight to SEND.
    mr_mode = 0; mr_lat = 0;
    send_pair(64'hDEADBEEF00000001, 64'hCAFEF00D00000002);
    wait_en(ok);
    repeat (25) @(posedge CLK);
    #1;
    send_pair(64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0);
    @(negedge CLK);
    chk("guard_exit_enable", ENABLE, 1);
    chk("guard_exit_byte0", DATA_IN, 8'h0F);
    mr_lat = -1;
    wait_idle();

    // Asynchronous reset during byte 9.
    send_pair(64'h8877665544332211, 64'h00FFEEDDCCBBAA99);
    wait_en(ok);
    repeat (9) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("async_rst_enable", ENABLE, 0);
    chk("async_rst_data", DATA_IN, 0);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_ready", OP_READY, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst_release", OP_READY, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ENABLE) n++;
      @(negedge CLK);
    end
    chk("no_residual_bytes", n, 0);
    @(posedge CLK);
    #1;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      mr_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      spur = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 30)) @(posedge CLK);
      #1;
      send_pair({$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_operand_serializer.md
FP_OPERAND_SERIALIZER -- requirements
Module: fp_operand_serializer

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 2: idle cycles forced between the end of one result burst and the next ENABLE.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles in WAIT_RES before an error is declared.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port OP_VALID  in  1  upstream operand pair valid.
REQ-006 SHALL have port OP_READY  out  1  block can accept an operand pair this cycle.
REQ-007 SHALL have port OP_A  in  64  IEEE-754 binary64 operand A.
REQ-008 SHALL have port OP_B  in  64  IEEE-754 binary64 operand B.
REQ-009 SHALL have port ENABLE  out  1  byte strobe to the multiplier.
REQ-010 SHALL have port DATA_IN  out  8  byte to the multiplier, valid when ENABLE=1.
REQ-011 SHALL have port MULT_READY  in  1  multiplier result-byte strobe (8 consecutive high cycles per result).
REQ-012 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-013 SHALL have port TIMEOUT_ERR  out  1  one-cycle pulse on WAIT_RES timeout.

Function
REQ-014 SHALL buffer at most two operand pairs: one active register and one pending register. OP_READY=1 whenever the pending register is empty.
REQ-015 Handshake: a pair SHALL be accepted on a cycle where OP_VALID && OP_READY. The pair loads the active register if it is free and the FSM is IDLE; otherwise it loads the pending register.
REQ-016 FSM states SHALL be IDLE, SEND, WAIT_RES, GUARD.
REQ-017 IDLE->SEND: SHALL occur the cycle after the active register holds a pair.
REQ-018 SEND: SHALL last exactly 16 consecutive cycles with ENABLE=1.
- Bytes 0-7 SHALL be OP_A[7:0] .. OP_A[63:56], LSB byte first.
- Bytes 8-15 SHALL be OP_B[7:0] .. OP_B[63:56].
- A 4-bit byte counter SHALL select the byte.
REQ-019 ENABLE SHALL be 0 in every state other than SEND; it SHALL never exceed 16 high cycles per pair. DATA_IN SHALL be 0 when ENABLE=0.
REQ-020 SEND->WAIT_RES: SHALL occur after the 16th byte.
REQ-021 WAIT_RES: SHALL count MULT_READY high cycles with a 3-bit counter. After the 8th high cycle, the FSM SHALL go to GUARD.
REQ-022 A MULT_READY gap inside a burst SHALL NOT reset the counter.
REQ-023 WAIT_RES timeout: if the state lasts TIMEOUT_CYCLES cycles without completing, the block SHALL pulse TIMEOUT_ERR and go to GUARD.
REQ-024 GUARD: SHALL hold GUARD_CYCLES cycles. It SHALL then free the active register, move pending to active if present, and go to SEND when a pair is present, else IDLE.
REQ-025 Simultaneous acceptance and GUARD exit: the accepted pair SHALL be placed so that arrival order is preserved, with no loss or duplication.
REQ-026 MULT_READY asserted outside WAIT_RES SHALL be ignored.
REQ-027 Minimum transaction period SHALL be 1 + 16 + (result latency) + 8 + GUARD_CYCLES cycles. Back-to-back pairs SHALL incur no extra IDLE cycle.

Reset
REQ-028 RESET=1 SHALL asynchronously force:
- FSM to IDLE, all counters to 0;
- both buffer registers invalid;
- ENABLE=0, DATA_IN=0, OP_READY=0 while RESET is held, OP_READY=1 the first cycle after release;
- BUSY=0, TIMEOUT_ERR=0.
REQ-029 Reset mid-SEND or mid-WAIT_RES SHALL discard all buffered pairs without completing the byte stream. The multiplier SHALL be reset by the same RESET.
REQ-030 Operand data registers SHALL need no reset; only valid flags, FSM and counters are reset.

Structure
REQ-031 The shared fp package SHALL hold:
- FSM state encoding;
- byte count 16 and result-byte count 8;
- binary64 width constant 64.
REQ-032 One sub-module is natural: fp_pair_buffer (the 2-entry active/pending holding buffer with valid flags). The FSM and byte mux SHALL stay in the top module.
REQ-033 Estimated size SHALL be 150-250 lines of RTL.

Verification
REQ-034 Single pair A=0x3FF0000000000000, B=0x4000000000000000 -> ENABLE high 16 cycles; DATA_IN = 00×6, F0, 3F, 00×7, 40; then after the model multiplier's 8 MULT_READY cycles, BUSY=0 after 2 guard cycles.
REQ-035 Three pairs offered back-to-back with OP_VALID held -> first two accepted immediately; OP_READY=0 until the first GUARD completes; all three streamed in order, none lost or duplicated.
REQ-036 MULT_READY never asserted -> TIMEOUT_ERR pulses exactly once, 64 cycles after WAIT_RES entry; the next pending pair is then streamed.
REQ-037 RESET asserted at byte 9 of SEND -> ENABLE drops in the same cycle (asynchronous); after release, OP_READY=1 and no residual bytes are sent.
REQ-038 MULT_READY high 4 cycles, low 3, high 4 -> GUARD entered after the 8th high cycle, not earlier.
REQ-039 Spurious MULT_READY pulses in IDLE and SEND -> no state change and no count carried into WAIT_RES.
